add_seq_ctrl: RTL

//  Multi-cycle wide-adder sequencer. Accepts DATA_W-bit operands over a valid/ready handshake.

---
 rtl/add_seq_pkg.sv | 26 ++
 rtl/add_slice.sv | 45 ++++
 rtl/add_seq_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
//   Shared types and helpers for the sequential wide adder (add_seq_ctrl).
//   - add_seq_state_t : controller states IDLE / RUN / DONE
//   - cnt_width()     : slice-counter width, max(1, $clog2(data_w/slice_w))
// ---------------------------------------------------------------------------
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_seq_state_t;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int data_w, input int slice_w);
    int ns;
    ns = data_w / slice_w;
    if (ns <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(ns);
    end
  endfunction

endpackage

// File: rtl/add_slice.sv
// ---------------------------------------------------------------------------
// add_slice
//   Combinational SLICE_W-bit ripple adder built as a chain of half adders
//   (two half adders plus an OR per bit).
// Ports:
//   a, b  in  SLICE_W  addends
//   ci    in  1        carry in
//   s     out SLICE_W  sum
//   co    out 1        carry out of the top bit
// ---------------------------------------------------------------------------
module add_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0]   c;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] t;

  // Ripple the carry through one half-adder pair per bit.
  always_comb begin
    c    = '0;
    p    = '0;
    g    = '0;
    t    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      p[i]     = a[i] ^ b[i];   // first half adder: a + b
      g[i]     = a[i] & b[i];
      s[i]     = p[i] ^ c[i];   // second half adder: partial + carry
      t[i]     = p[i] & c[i];
      c[i + 1] = g[i] | t[i];
    end
  end

  assign co = c[SLICE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add_seq_ctrl
//   Multi-cycle wide adder. Operands are accepted over a valid/ready
//   handshake, added SLICE_W bits per cycle on one shared add_slice with the
//   carry rippled between cycles, and {co, sum} is returned over a second
//   valid/ready handshake. Result valid NS = DATA_W/SLICE_W cycles after
//   acceptance.
// Optional feature macro: ADD_SEQ_SUB_EN
//   When defined, a 'sub' input exists; sub=1 computes a-b (b inverted per
//   slice, initial carry 1), and co=1 then means "no borrow".
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       operands valid
//   in_ready   out  1       block can accept operands (IDLE only)
//   a, b       in   DATA_W  operands
//   sub        in   1       (ADD_SEQ_SUB_EN only) 1 = subtract
//   out_valid  out  1       sum/co hold the final result
//   out_ready  in   1       consumer takes the result
//   sum        out  DATA_W  result modulo 2^DATA_W
//   co         out  1       carry out of the MSB slice
//   busy       out  1       high whenever not IDLE
// ---------------------------------------------------------------------------
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
`ifdef ADD_SEQ_SUB_EN
  input  logic              sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              co,
  output logic              busy
);

  localparam int NS    = DATA_W / SLICE_W;
  localparam int CNT_W = cnt_width(DATA_W, SLICE_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NS - 1);

  generate
    if (DATA_W % SLICE_W != 0) begin : g_bad_width
      $fatal(1, "add_seq_ctrl: DATA_W must be a multiple of SLICE_W");
    end
  endgenerate

  add_seq_state_t    state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              co_q, co_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
`ifdef ADD_SEQ_SUB_EN
  logic              sub_q, sub_d;
`endif

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W-1:0] s_sl;
  logic               c_sl;
  logic [DATA_W-1:0]  sum_run;

  // AND-OR mux of the captured operands down to the slice selected by cnt_q.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NS; i++) begin
      a_sl = a_sl | (a_q[i*SLICE_W +: SLICE_W] & {SLICE_W{cnt_q == CNT_W'(i)}});
      b_sl = b_sl | (b_q[i*SLICE_W +: SLICE_W] & {SLICE_W{cnt_q == CNT_W'(i)}});
    end
  end

`ifdef ADD_SEQ_SUB_EN
  // Two's-complement subtract: invert b here, the +1 enters as initial carry.
  assign b_eff = sub_q ? ~b_sl : b_sl;
`else
  assign b_eff = b_sl;
`endif

  add_slice #(
    .SLICE_W (SLICE_W)
  ) u_add_slice (
    .a  (a_sl),
    .b  (b_eff),
    .ci (carry_q),
    .s  (s_sl),
    .co (c_sl)
  );

  // Result with the active slice replaced by the adder output.
  always_comb begin
    sum_run = sum_q;
    for (int i = 0; i < NS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        sum_run[i*SLICE_W +: SLICE_W] = s_sl;
      end else begin
        sum_run[i*SLICE_W +: SLICE_W] = sum_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    co_d        = co_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef ADD_SEQ_SUB_EN
    sub_d       = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          cnt_d      = '0;
`ifdef ADD_SEQ_SUB_EN
          sub_d      = sub;
          carry_d    = sub;
`else
          carry_d    = 1'b0;
`endif
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      RUN: begin
        sum_d   = sum_run;
        carry_d = c_sl;
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          co_d        = c_sl;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        // Returning to IDLE here means the next accept is one cycle later.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        cnt_d       = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      co_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      co_q        <= co_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ADD_SEQ_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign co        = co_q;
  assign busy      = busy_q;

endmodule
